adsd_risc_fetch: RTL and testbench
==================================

# adsd_risc_fetch

Instruction-fetch and program-counter stage of the 16-bit ADSD RISC core. It owns the PC and the instruction register, and fetches words from instruction memory over a req/ready handshake. It presents the opcode to the combinational control unit for one cycle, then consumes that unit's pc_ld, ctrl_branch and ctrl_jump to select the next PC.

## Interface
- ADDR_W, 16, PC / instruction-memory word-address width
- INSTR_W, 16, instruction width; opcode is instr[15:12]
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- run  in  1  1 = allow new fetches; 0 = stop at the next instruction boundary
- pc_ld  in  1  from control: advance PC at end of EXEC
- ctrl_branch  in  1  from control: conditional branch taken
- ctrl_jump  in  1  from control: jump
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rdata  in  INSTR_W  fetched word
- imem_ready  in  1  rdata valid; transfer completes when imem_req && imem_ready
- pc  out  ADDR_W  address of current instruction
- instr  out  INSTR_W  instruction register
- opcode  out  4  instr[15:12], to control unit
- instr_valid  out  1  high exactly during EXEC
- halted  out  1  core stopped because pc_ld was low in EXEC

## Operation
- States:
  - IDLE: run=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr <= imem_rdata, then EXEC. Otherwise hold req and address stable.
  - EXEC: instr_valid=1. With pc_ld=1: pc <= next_pc, then FETCH if run=1, else IDLE. With pc_ld=0: HALT.
  - HALT: halted=1. Exit only by reset.
- next_pc priority, jump > branch > sequential:
  - ctrl_jump: {pc_plus1[15:12], instr[11:0]}
  - ctrl_branch: pc_plus1 + sign_extend(instr[3:0])
  - otherwise: pc_plus1 = pc + 1
- All PC arithmetic is modulo 2^ADDR_W: 16'hFFFF + 1 = 16'h0000, and branch targets wrap both ways.
- imem_ready outside FETCH is ignored; imem_rdata is sampled only on the handshake cycle.
- A run deassert during FETCH does not abort the request. The fetch completes, EXEC executes, then the FSM enters IDLE.
- Reset asserted mid-fetch: imem_req drops asynchronously and the in-flight word is discarded.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, halted=0. Perf counters are 0 when compiled in.
- With zero-wait memory (ready in the cycle req rises): 2 cycles per instruction, FETCH then EXEC.
- Each wait cycle adds 1 cycle.
- The first imem_req rises in the cycle after the first edge that samples run=1 in IDLE.
- pc, instr and opcode are registered and stable throughout EXEC. The control inputs are sampled at the edge ending EXEC.
- halted rises in the cycle after the EXEC that saw pc_ld=0.

## Configuration
- ADSD_RISC_FETCH_PERF_EN defined:
  - Adds outputs instret_cnt (16) and taken_cnt (16).
  - instret_cnt increments on every EXEC with pc_ld=1.
  - taken_cnt increments on every such EXEC that also has ctrl_branch or ctrl_jump set.
  - Both counters wrap FFFF -> 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package adsd_risc_pkg:
  - fetch_state_t enum (IDLE, FETCH, EXEC, HALT)
  - OPCODE_W = 4
  - opcode localparams shared with the control unit
- One sub-module, adsd_risc_next_pc: combinational. Inputs pc, instr, ctrl_branch, ctrl_jump; output next_pc.

## Test plan
- Reset, run=1, zero-wait memory, three sequential non-branch words -> imem_addr 0, 1, 2, one EXEC per 2 cycles, final pc=3.
- imem_ready delayed 3 cycles -> imem_req and imem_addr held constant for 4 cycles; instr captured only on the ready cycle.
- EXEC at pc=16'h0010, instr[3:0]=4'hE, ctrl_branch=1 -> next fetch address 16'h000F. Same with ctrl_jump=1 and instr[11:0]=12'h123 -> address 16'h0123, jump winning.
- pc=16'hFFFF, sequential instruction -> next fetch address 16'h0000.
- run dropped mid-FETCH -> fetch completes, one EXEC, state IDLE, no further imem_req. Separately, pc_ld=0 in EXEC -> halted=1 permanently until rst=0.
- With ADSD_RISC_FETCH_PERF_EN, 5 instructions of which 2 take a branch or jump -> instret_cnt=5, taken_cnt=2.

Source files
------------

// File: rtl/adsd_risc_pkg.sv
// Shared types and constants for the ADSD RISC fetch stage and its control unit.
package adsd_risc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int OPCODE_W = 4;

  // Opcode map, kept in one place so fetch and control decode agree
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_LD  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_ST  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h7;

endpackage

// File: rtl/adsd_risc_next_pc.sv
// Next-PC selection: jump (page-relative) beats branch (4-bit signed offset) beats pc+1.
module adsd_risc_next_pc #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ctrl_branch,
  input  logic               ctrl_jump,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] br_off;
  logic              unused_hi;

  assign pc_plus1  = pc + ADDR_W'(1);
  assign br_off    = {{(ADDR_W-4){instr[3]}}, instr[3:0]};
  assign unused_hi = ^instr[INSTR_W-1:12];

  // Jump keeps the upper bits of pc+1 and replaces the low 12 bits
  always_comb begin
    next_pc = pc_plus1;
    if (ctrl_jump) begin
      next_pc = {pc_plus1[ADDR_W-1:12], instr[11:0]};
    end else if (ctrl_branch) begin
      next_pc = pc_plus1 + br_off;
    end
  end

endmodule

// File: rtl/adsd_risc_fetch.sv
// Fetch/PC stage: IDLE -> FETCH (req/ready) -> EXEC -> FETCH/IDLE/HALT.
// Optional perf counters instret_cnt/taken_cnt under ADSD_RISC_FETCH_PERF_EN.
module adsd_risc_fetch
  import adsd_risc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                pc_ld,
  input  logic                ctrl_branch,
  input  logic                ctrl_jump,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ready,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
`ifdef ADSD_RISC_FETCH_PERF_EN
  output logic [15:0]         instret_cnt,
  output logic [15:0]         taken_cnt,
`endif
  output logic                halted
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               req_q;
  logic               valid_q;
  logic               halted_q;

  adsd_risc_next_pc #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_next_pc (
    .pc         (pc_q),
    .instr      (instr_q),
    .ctrl_branch(ctrl_branch),
    .ctrl_jump  (ctrl_jump),
    .next_pc    (pc_d)
  );

  // Outputs are registered alongside the state so they change only at edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          valid_q <= 1'b0;
          if (pc_ld) begin
            pc_q <= pc_d;
            if (run) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1:INSTR_W-OPCODE_W];
  assign instr_valid = valid_q;
  assign halted      = halted_q;

`ifdef ADSD_RISC_FETCH_PERF_EN
  logic [15:0] instret_q;
  logic [15:0] taken_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
      taken_q   <= '0;
    end else if (state_q == EXEC && pc_ld) begin
      instret_q <= instret_q + 16'd1;
      if (ctrl_branch || ctrl_jump) begin
        taken_q <= taken_q + 16'd1;
      end
    end
  end

  assign instret_cnt = instret_q;
  assign taken_cnt   = taken_q;
`endif

endmodule

// File: tb/tb_adsd_risc_fetch.sv
// Directed plus randomized bench for adsd_risc_fetch against a transaction-level PC model.
module tb_adsd_risc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        pc_ld = 1'b0;
  logic        ctrl_branch = 1'b0;
  logic        ctrl_jump = 1'b0;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        halted;
`ifdef ADSD_RISC_FETCH_PERF_EN
  logic [15:0] instret_cnt;
  logic [15:0] taken_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int m_pc = 0;
  logic [15:0] m_instr = '0;
  int m_instret = 0;
  int m_taken = 0;

  adsd_risc_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .pc_ld      (pc_ld),
    .ctrl_branch(ctrl_branch),
    .ctrl_jump  (ctrl_jump),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
`ifdef ADSD_RISC_FETCH_PERF_EN
    .instret_cnt(instret_cnt),
    .taken_cnt  (taken_cnt),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef ADSD_RISC_FETCH_PERF_EN
    check({tag, "_instret"}, {16'd0, instret_cnt}, m_instret);
    check({tag, "_taken"}, {16'd0, taken_cnt}, m_taken);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules, using plain integer arithmetic mod 65536
  function automatic int exp_next(input int cur, input logic [15:0] w, input bit br, input bit jp);
    int p1;
    int wi;
    int off;
    p1 = (cur + 1) % 65536;
    wi = int'(w);
    if (jp) return (p1 / 4096) * 4096 + (wi % 4096);
    if (br) begin
      off = wi % 16;
      if (off >= 8) off -= 16;
      return (p1 + off + 65536) % 65536;
    end
    return p1;
  endfunction

  // Entered one tick after the edge that put the DUT in FETCH
  task automatic run_instr(input logic [15:0] word, input int waits, input bit br,
                           input bit jp, input bit ld, input bit run_after);
    int prev_pc;
    for (int i = 0; i < waits; i++) begin
      check("req_wait", {31'd0, imem_req}, 1);
      check("addr_wait", {16'd0, imem_addr}, m_pc);
      check("instr_hold", {16'd0, instr}, {16'd0, m_instr});
      imem_ready = 1'b0;
      imem_rdata = 16'($urandom);
      step();
    end
    check("req", {31'd0, imem_req}, 1);
    check("addr", {16'd0, imem_addr}, m_pc);
    imem_rdata = word;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    m_instr = word;
    check("valid", {31'd0, instr_valid}, 1);
    check("instr", {16'd0, instr}, {16'd0, word});
    check("opcode", {28'd0, opcode}, int'(word) / 4096);
    check("pc_exec", {16'd0, pc}, m_pc);
    check("req_exec", {31'd0, imem_req}, 0);
    pc_ld = ld;
    ctrl_branch = br;
    ctrl_jump = jp;
    run = run_after;
    step();
    pc_ld = 1'b0;
    ctrl_branch = 1'b0;
    ctrl_jump = 1'b0;
    imem_ready = 1'b0;
    prev_pc = m_pc;
    if (ld) begin
      m_pc = exp_next(m_pc, word, br, jp);
      m_instret = (m_instret + 1) % 65536;
      if (br || jp) m_taken = (m_taken + 1) % 65536;
    end
    $display("instr pc=%04h word=%04h waits=%0d br=%0d jp=%0d ld=%0d next_pc=%04h",
             prev_pc[15:0], word, waits, br, jp, ld, m_pc[15:0]);
    check("valid_off", {31'd0, instr_valid}, 0);
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    repeat (2) step();
    check("rst_req", {31'd0, imem_req}, 0);
    check("rst_pc", {16'd0, pc}, 0);
    check("rst_instr", {16'd0, instr}, 0);
    check("rst_valid", {31'd0, instr_valid}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check_perf("rst");

    rst = 1'b1;
    step();
    check("idle_no_req", {31'd0, imem_req}, 0);
    run = 1'b1;
    step();

    // Three sequential zero-wait words
    run_instr(16'h1000, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr(16'h2001, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr(16'h3002, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("seq_pc3", {16'd0, pc}, 3);

    run_instr(16'h4ABC, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr(16'h7010, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("jump_to_10", {16'd0, imem_addr}, 16'h0010);
    run_instr(16'h600E, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("branch_back", {16'd0, imem_addr}, 16'h000F);
    run_instr(16'h7123, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("jump_wins", {16'd0, imem_addr}, 16'h0123);
    run_instr(16'h7000, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(16'h600E, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("branch_wrap_neg", {16'd0, imem_addr}, 16'hFFFF);
    run_instr(16'h1111, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("seq_wrap", {16'd0, imem_addr}, 16'h0000);
    run_instr(16'h6007, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    check("branch_fwd", {16'd0, imem_addr}, 16'h0008);
    check_perf("directed");

    for (int n = 0; n < 24; n++) begin
      run_instr(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    check_perf("random");

    // run drops during FETCH: fetch completes, one EXEC, then IDLE
    run = 1'b0;
    run_instr(16'h2345, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      check("idle_req", {31'd0, imem_req}, 0);
      check("idle_pc", {16'd0, pc}, m_pc);
      check("idle_halted", {31'd0, halted}, 0);
      step();
    end
    imem_ready = 1'b0;
    run = 1'b1;
    step();

    // pc_ld low in EXEC halts until reset
    run_instr(16'($urandom), 1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      check("halt_flag", {31'd0, halted}, 1);
      check("halt_req", {31'd0, imem_req}, 0);
      check("halt_pc", {16'd0, pc}, m_pc);
      step();
    end
    check_perf("halt");

    rst = 1'b0;
    #1;
    check("unhalt", {31'd0, halted}, 0);
    step();
    rst = 1'b1;
    run = 1'b1;
    imem_ready = 1'b0;
    m_pc = 0;
    m_instr = '0;
    m_instret = 0;
    m_taken = 0;
    step();
    check("refetch_req", {31'd0, imem_req}, 1);

    // Reset in the middle of a fetch cycle drops req at once and loses the word
    imem_rdata = 16'hDEAD;
    #3;
    rst = 1'b0;
    #1;
    check("async_req_drop", {31'd0, imem_req}, 0);
    imem_ready = 1'b1;
    step();
    check("discard_instr", {16'd0, instr}, 0);
    check("discard_valid", {31'd0, instr_valid}, 0);
    rst = 1'b1;
    imem_ready = 1'b0;
    run = 1'b1;
    step();
    run_instr(16'h2222, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr(16'h7055, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(16'h3333, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_instr(16'h6003, 0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_instr(16'h4444, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    check("final_pc", {16'd0, pc}, m_pc);
    check_perf("five");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
